// File: rtl/npm_mc.sv
// npm_mc: NP-core AXI4 master. Arbitrates NCORE np cores onto one AXI4 master port. Each granted
// job runs as a chain of INCR bursts. A burst is split at MAXBL beats and at 4KB address
// boundaries.
//
// Build option: define NPM_RR_ARB_EN for round-robin arbitration. In the default build the
// lowest requesting index wins (fixed priority).
//
// Ports
//   m_axi_aclk, m_axi_arst         clock, asynchronous active-high reset
//   m_axi_aw*/w*/b*/ar*/r*         AXI4 master (INCR bursts, full strobes, constant ID)
//   npc_req/gnt                    per-core job request / one-cycle grant pulse
//   npc_rwn/adr/len                per-core job descriptor, sampled when the core wins
//   npc_wdt                        per-core write data
//   npc_rdt                        shared read data
//   npc_ack/lst                    beat accepted / final beat of the job (running core only)
//   npc_done/err                   job-complete pulse, with error flag
module npm_mc #(
  parameter int unsigned NCORE = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned MAXBL = 256,
  parameter logic [5:0]  AXID  = 6'd0
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_arst,
  output logic [5:0]            m_axi_awid,
  output logic [31:0]           m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic [3:0]            m_axi_awregion,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DW-1:0]         m_axi_wdata,
  output logic [DW/8-1:0]       m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [5:0]            m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [5:0]            m_axi_arid,
  output logic [31:0]           m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic [3:0]            m_axi_arregion,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [5:0]            m_axi_rid,
  input  logic [DW-1:0]         m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [NCORE-1:0]      npc_req,
  output logic [NCORE-1:0]      npc_gnt,
  input  logic [NCORE-1:0]      npc_rwn,
  input  logic [32*NCORE-1:0]   npc_adr,
  input  logic [32*NCORE-1:0]   npc_len,
  input  logic [DW*NCORE-1:0]   npc_wdt,
  output logic [DW-1:0]         npc_rdt,
  output logic [NCORE-1:0]      npc_ack,
  output logic [NCORE-1:0]      npc_lst,
  output logic [NCORE-1:0]      npc_done,
  output logic [NCORE-1:0]      npc_err
);

  localparam int unsigned BB = DW / 8;
  localparam int unsigned SZ = $clog2(BB);
  localparam int unsigned IW = (NCORE > 1) ? $clog2(NCORE) : 1;

  typedef enum logic [2:0] {StIdle, StZero, StAdr, StDat, StRsp} state_e;

  state_e             state_q, state_d;
  logic [NCORE-1:0]   run_q, run_d;
  logic [NCORE-1:0]   gnt_q, gnt_d;
  logic [NCORE-1:0]   done_q, done_d;
  logic               rwn_q, rwn_d;
  logic [31:0]        adr_q, adr_d;
  logic [31:0]        len_q, len_d;     // beats remaining, including the current burst
  logic [7:0]         axlen_q, axlen_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               any_req;
  logic [IW-1:0]      win;
  logic [NCORE-1:0]   win_oh;
  logic [31:0]        win_adr, win_len;
  logic [8:0]         bl_cur, bl_new;
  logic [31:0]        nxt_adr, nxt_len, src_adr, src_len;
  logic [7:0]         axlen_new;
  logic               last_burst, burst_end;
  logic               w_hs, r_hs;

  logic unused_ids;
  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  // Beats in the next burst: limited by job remainder, MAXBL and the distance to the 4KB page end.
  function automatic logic [8:0] calc_bl(input logic [31:0] a, input logic [31:0] l);
    logic [31:0] b;
    logic [31:0] pg;
    b  = l;
    pg = (32'd4096 - {20'd0, a[11:0]}) >> SZ;
    if (b > MAXBL) b = MAXBL;
    if (b > pg) b = pg;
    return b[8:0];
  endfunction

  assign any_req = |npc_req;

`ifdef NPM_RR_ARB_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // Search starts at the core after the previous winner.
  always_comb begin
    logic found;
    int unsigned idx;
    found = 1'b0;
    idx   = 0;
    win   = '0;
    for (int unsigned i = 0; i < NCORE; i++) begin
      idx = (int'(ptr_q) + i) % NCORE;
      if (!found && npc_req[idx]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == StIdle && any_req) begin
      ptr_d = (int'(win) == NCORE - 1) ? '0 : win + IW'(1);
    end
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_arst) begin
    if (m_axi_arst) ptr_q <= '0;
    else            ptr_q <= ptr_d;
  end
`else
  always_comb begin
    logic found;
    found = 1'b0;
    win   = '0;
    for (int unsigned i = 0; i < NCORE; i++) begin
      if (!found && npc_req[i]) begin
        win   = IW'(i);
        found = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  assign win_adr = npc_adr[32*int'(win) +: 32];
  assign win_len = npc_len[32*int'(win) +: 32];

  // Burst bookkeeping: next burst comes from the winner's descriptor or from the advanced job.
  assign bl_cur     = {1'b0, axlen_q} + 9'd1;
  assign nxt_adr    = adr_q + ({23'd0, bl_cur} << SZ);
  assign nxt_len    = len_q - {23'd0, bl_cur};
  assign last_burst = (nxt_len == 32'd0);
  assign src_adr    = (state_q == StIdle) ? win_adr : nxt_adr;
  assign src_len    = (state_q == StIdle) ? win_len : nxt_len;
  assign bl_new     = calc_bl(src_adr, src_len);
  assign axlen_new  = 8'(bl_new - 9'd1);

  assign w_hs = m_axi_wvalid & m_axi_wready;
  assign r_hs = m_axi_rvalid & m_axi_rready;

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    gnt_d     = '0;
    done_d    = '0;
    rwn_d     = rwn_q;
    adr_d     = adr_q;
    len_d     = len_q;
    axlen_d   = axlen_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    burst_end = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          gnt_d = win_oh;
          run_d = win_oh;
          rwn_d = npc_rwn[win];
          adr_d = win_adr;
          len_d = win_len;
          err_d = 1'b0;
          if (win_len == 32'd0) begin
            state_d = StZero;
          end else begin
            axlen_d = axlen_new;
            state_d = StAdr;
          end
        end
      end
      StZero: begin
        done_d  = run_q;
        run_d   = '0;
        state_d = StIdle;
      end
      StAdr: begin
        if (rwn_q ? m_axi_arready : m_axi_awready) begin
          cnt_d   = '0;
          state_d = StDat;
        end
      end
      StDat: begin
        if (!rwn_q) begin
          if (m_axi_wready) begin
            cnt_d = cnt_q + 8'd1;
            if (m_axi_wlast) state_d = StRsp;
          end
        end else if (m_axi_rvalid) begin
          cnt_d = cnt_q + 8'd1;
          if (m_axi_rresp != 2'b00) err_d = 1'b1;
          // rlast, not the beat counter, ends a read burst
          if (m_axi_rlast) burst_end = 1'b1;
        end
      end
      StRsp: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) err_d = 1'b1;
          burst_end = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (burst_end) begin
      if (last_burst) begin
        done_d  = run_q;
        run_d   = '0;
        state_d = StIdle;
      end else begin
        adr_d   = nxt_adr;
        len_d   = nxt_len;
        axlen_d = axlen_new;
        state_d = StAdr;
      end
    end
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_arst) begin
    if (m_axi_arst) begin
      state_q <= StIdle;
      run_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rwn_q   <= 1'b0;
      adr_q   <= '0;
      len_q   <= '0;
      axlen_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rwn_q   <= rwn_d;
      adr_q   <= adr_d;
      len_q   <= len_d;
      axlen_q <= axlen_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // AXI address channels share the latched burst descriptor.
  assign m_axi_awid     = AXID;
  assign m_axi_awaddr   = adr_q;
  assign m_axi_awlen    = axlen_q;
  assign m_axi_awsize   = 3'(SZ);
  assign m_axi_awburst  = 2'b01;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = 4'b0010;
  assign m_axi_awprot   = 3'b000;
  assign m_axi_awqos    = 4'd0;
  assign m_axi_awregion = 4'd0;
  assign m_axi_awvalid  = (state_q == StAdr) & ~rwn_q;

  assign m_axi_arid     = AXID;
  assign m_axi_araddr   = adr_q;
  assign m_axi_arlen    = axlen_q;
  assign m_axi_arsize   = 3'(SZ);
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = 4'b0010;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_arqos    = 4'd0;
  assign m_axi_arregion = 4'd0;
  assign m_axi_arvalid  = (state_q == StAdr) & rwn_q;

  assign m_axi_wvalid = (state_q == StDat) & ~rwn_q;
  assign m_axi_wlast  = m_axi_wvalid & (cnt_q == axlen_q);
  assign m_axi_wstrb  = '1;
  assign m_axi_bready = (state_q == StRsp);
  assign m_axi_rready = (state_q == StDat) & rwn_q;

  always_comb begin
    m_axi_wdata = '0;
    for (int unsigned i = 0; i < NCORE; i++) begin
      if (run_q[i]) m_axi_wdata = m_axi_wdata | npc_wdt[DW*i +: DW];
    end
  end

  assign npc_rdt  = m_axi_rdata;
  assign npc_gnt  = gnt_q;
  assign npc_ack  = run_q & {NCORE{w_hs | r_hs}};
  assign npc_lst  = npc_ack &
                    {NCORE{last_burst & (w_hs ? m_axi_wlast : m_axi_rlast)}};
  assign npc_done = done_q;
  assign npc_err  = done_q & {NCORE{err_q}};

endmodule

// File: tb/tb_npm_mc.sv
// Directed bench for npm_mc (NCORE=4, DW=32, MAXBL=256, AXID=5) with a simple AXI slave model.
module tb_npm_mc;
  localparam int NC = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [5:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awlock, arlock, awvalid, awready, arvalid, arready;
  logic [3:0]  awcache, arcache, awqos, arqos, awregion, arregion;
  logic [DW-1:0] wdata, rdata, npc_rdt;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;
  logic [NC-1:0] npc_req, npc_gnt, npc_rwn, npc_ack, npc_lst, npc_done, npc_err;
  logic [32*NC-1:0] npc_adr, npc_len;
  logic [DW*NC-1:0] npc_wdt;

  npm_mc #(.NCORE(NC), .DW(DW), .MAXBL(256), .AXID(6'd5)) dut (
    .m_axi_aclk(clk), .m_axi_arst(rst),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awregion(awregion),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arregion(arregion),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready),
    .npc_req(npc_req), .npc_gnt(npc_gnt), .npc_rwn(npc_rwn), .npc_adr(npc_adr),
    .npc_len(npc_len), .npc_wdt(npc_wdt), .npc_rdt(npc_rdt), .npc_ack(npc_ack),
    .npc_lst(npc_lst), .npc_done(npc_done), .npc_err(npc_err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Monitor / slave state
  int cyc = 0;
  logic [31:0] aw_addr[$], aw_len[$], ar_addr[$], ar_len[$];
  int gnt_list[$];
  int addr_cycles, wbeats, wlast_cnt, wlast_at, wdata_bad, b_cyc, rlast_cyc, done_cyc, gnt_cyc;
  int err_stray;
  int ack_cnt[NC], lst_cnt[NC], lst_at[NC], done_cnt[NC];
  logic done_err[NC];
  logic [2:0] aw_size;
  logic [5:0] aw_id;
  int b_owed = 0, rd_left = 0, rd_idx = 0, err_beat = -1, cur_core = 0;

  task automatic clr();
    aw_addr.delete(); aw_len.delete(); ar_addr.delete(); ar_len.delete(); gnt_list.delete();
    addr_cycles = 0; wbeats = 0; wlast_cnt = 0; wlast_at = 0; wdata_bad = 0; err_stray = 0;
    b_cyc = -1; rlast_cyc = -1; done_cyc = -1; gnt_cyc = -1;
    for (int c = 0; c < NC; c++) begin
      ack_cnt[c] = 0; lst_cnt[c] = 0; lst_at[c] = 0; done_cnt[c] = 0; done_err[c] = 1'b0;
    end
  endtask

  // Sample at negedge: values seen here are the handshakes taken at the next posedge.
  initial begin
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    bvalid = 1'b0; bresp = 2'b00; bid = 6'd5;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = 6'd5;
    clr();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (awvalid || arvalid) addr_cycles++;
        if (awvalid && awready) begin
          aw_addr.push_back(awaddr); aw_len.push_back({24'd0, awlen});
          aw_size = awsize; aw_id = awid;
        end
        if (arvalid && arready) begin
          ar_addr.push_back(araddr); ar_len.push_back({24'd0, arlen});
          rd_left = int'(arlen) + 1;
        end
        if (wvalid && wready) begin
          wbeats++;
          if (wdata !== 32'(32'hC0DE_0000 + cur_core) || wstrb !== 4'hF) wdata_bad++;
          if (wlast) begin wlast_cnt++; wlast_at = wbeats; b_owed++; end
        end
        if (bvalid && bready) begin b_owed--; b_cyc = cyc; end
        if (rvalid && rready) begin
          rd_left--; rd_idx++;
          if (rlast) rlast_cyc = cyc;
        end
        for (int c = 0; c < NC; c++) begin
          if (npc_ack[c]) ack_cnt[c]++;
          if (npc_lst[c]) begin lst_cnt[c]++; lst_at[c] = ack_cnt[c]; end
          if (npc_gnt[c]) begin gnt_list.push_back(c); gnt_cyc = cyc; end
          if (npc_done[c]) begin done_cnt[c]++; done_err[c] = npc_err[c]; done_cyc = cyc; end
          if (npc_err[c] && !npc_done[c]) err_stray++;
        end
      end
      @(posedge clk);
      #1;
      bvalid = (b_owed > 0);
      rvalid = (rd_left > 0);
      rlast  = (rd_left == 1);
      rdata  = 32'(32'hA500_0000 + rd_idx);
      rresp  = (rd_idx == err_beat) ? 2'b10 : 2'b00;
    end
  end

  task automatic run_job(input int c, input logic rwn, input logic [31:0] a, input logic [31:0] l);
    int t;
    clr();
    cur_core = c;
    npc_rwn[c] = rwn;
    npc_adr[c*32 +: 32] = a;
    npc_len[c*32 +: 32] = l;
    npc_req[c] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!npc_gnt[c] && t < 50);
    if (!npc_gnt[c]) check("gnt_timeout", 0, 1);
    npc_req[c] = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!npc_done[c] && t < 2000);
    if (!npc_done[c]) check("done_timeout", 0, 1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    int t;
    int exp_order[5];
    rst = 1'b1;
    npc_req = '0; npc_rwn = '0; npc_adr = '0; npc_len = '0;
    for (int c = 0; c < NC; c++) npc_wdt[c*DW +: DW] = 32'(32'hC0DE_0000 + c);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valids", {awvalid, arvalid, wvalid, rready, bready}, 5'b0);
    check("rst_gnt_ack", {npc_gnt, npc_ack, npc_lst}, 12'b0);
    check("rst_done_err", {npc_done, npc_err}, 8'b0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // Write core0 0x1000 len 4: single burst
    run_job(0, 1'b0, 32'h1000, 4);
    check("t1_aw_n", aw_addr.size(), 1);
    check("t1_aw_addr", aw_addr[0], 32'h1000);
    check("t1_aw_len", aw_len[0], 3);
    check("t1_aw_size", aw_size, 3'd2);
    check("t1_aw_id", aw_id, 6'd5);
    check("t1_aw_const", {awburst, awlock, awcache, awprot, awqos, awregion},
          {2'b01, 1'b0, 4'b0010, 3'b0, 4'b0, 4'b0});
    check("t1_ar_n", ar_addr.size(), 0);
    check("t1_wbeats", wbeats, 4);
    check("t1_wlast", {wlast_cnt[7:0], wlast_at[7:0]}, {8'd1, 8'd4});
    check("t1_wdata", wdata_bad, 0);
    check("t1_ack", ack_cnt[0], 4);
    check("t1_lst", {lst_cnt[0][7:0], lst_at[0][7:0]}, {8'd1, 8'd4});
    check("t1_done", {done_cnt[0][7:0], 7'd0, done_err[0]}, {8'd1, 8'd0});
    check("t1_done_cyc", done_cyc, b_cyc + 1);

    // Read core2 0x0FF8 len 4: split at the 4KB boundary
    run_job(2, 1'b1, 32'h0FF8, 4);
    check("t2_ar_n", ar_addr.size(), 2);
    check("t2_ar0", {ar_addr[0], ar_len[0]}, {32'h0FF8, 32'd1});
    check("t2_ar1", {ar_addr[1], ar_len[1]}, {32'h1000, 32'd1});
    check("t2_ar_const", {arid, arsize, arburst, arlock, arcache, arprot, arqos, arregion},
          {6'd5, 3'd2, 2'b01, 1'b0, 4'b0010, 3'b0, 4'b0, 4'b0});
    check("t2_aw_n", aw_addr.size(), 0);
    check("t2_ack", ack_cnt[2], 4);
    check("t2_lst", {lst_cnt[2][7:0], lst_at[2][7:0]}, {8'd1, 8'd4});
    check("t2_done", {done_cnt[2][7:0], 7'd0, done_err[2]}, {8'd1, 8'd0});
    check("t2_done_cyc", done_cyc, rlast_cyc + 1);
    check("t2_other_ack", ack_cnt[0] + ack_cnt[1] + ack_cnt[3], 0);

    // Write core1 adr 0 len 600: bursts of 256, 256, 88
    run_job(1, 1'b0, 32'h0, 600);
    check("t3_aw_n", aw_addr.size(), 3);
    check("t3_aw0", {aw_addr[0], aw_len[0]}, {32'h000, 32'd255});
    check("t3_aw1", {aw_addr[1], aw_len[1]}, {32'h400, 32'd255});
    check("t3_aw2", {aw_addr[2], aw_len[2]}, {32'h800, 32'd87});
    check("t3_wbeats", wbeats, 600);
    check("t3_wlast_cnt", wlast_cnt, 3);
    check("t3_wdata", wdata_bad, 0);
    check("t3_ack_lst", {ack_cnt[1][15:0], lst_at[1][15:0]}, {16'd600, 16'd600});
    check("t3_done", done_cnt[1], 1);

    // Read core3 len 3 with SLVERR on the 2nd beat, then a clean job
    rd_idx = 0; err_beat = 1;
    run_job(3, 1'b1, 32'h2000, 3);
    err_beat = -1;
    check("t5_ack", ack_cnt[3], 3);
    check("t5_done_err", {done_cnt[3][7:0], 7'd0, done_err[3]}, {8'd1, 8'd1});
    check("t5_err_stray", err_stray, 0);
    run_job(3, 1'b1, 32'h3000, 1);
    check("t5_next_err", {done_cnt[3][7:0], 7'd0, done_err[3]}, {8'd1, 8'd0});

    // Zero-length job on core1
    run_job(1, 1'b0, 32'h4000, 0);
    check("t6_done_cyc", done_cyc, gnt_cyc + 1);
    check("t6_no_addr", addr_cycles, 0);
    check("t6_done", {done_cnt[1][7:0], 7'd0, done_err[1]}, {8'd1, 8'd0});
    check("t6_ack", ack_cnt[1], 0);

    // Arbitration after reset: all cores hold req, len 1 reads
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 clr();
    for (int c = 0; c < NC; c++) begin
      npc_rwn[c] = 1'b1;
      npc_adr[c*32 +: 32] = 32'(32'h5000 + c * 32'h100);
      npc_len[c*32 +: 32] = 32'd1;
    end
    npc_req = 4'b1111;
    t = 0;
    while (gnt_list.size() < 5 && t < 500) begin @(posedge clk); t++; end
    #1 npc_req = '0;
    t = 0;
    while ((done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3]) < 5 && t < 100) begin
      @(posedge clk); t++;
    end
    #2;
`ifdef NPM_RR_ARB_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    check("t4_gnt_n", gnt_list.size(), 5);
    for (int i = 0; i < 5; i++) check($sformatf("t4_gnt%0d", i), gnt_list[i], exp_order[i]);
    check("t4_done_n", done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3], 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end
endmodule
